// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared arbitration mode constants and index-width helper
package mux_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Source index width; a single channel still needs one bit to carry a port.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = ARB_RR,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  always_comb begin
    int start;
    int idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = (MODE == ARB_FIXED) ? 0 : int'(ptr);
    // A pointer past the last channel (non power-of-two N) restarts at 0.
    if (start >= N) start = 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - N-channel arbitrated mux with registered valid/ready output
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 2,
  parameter int MODE  = ARB_RR,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_word;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load     = !out_valid || out_ready;
  assign in_ready = reset ? '0 : (grant & {N{load}});
  assign xfer     = |in_ready;

  // AND-OR select so unselected channels cannot leak X into the output.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      sel_word = sel_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer && MODE == ARB_RR) begin
      ptr <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed self-checking bench for mux_arb_reg
module tb_mux_arb_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // N=2, WIDTH=32, round-robin
  logic [63:0] a_data = '0;
  logic [1:0]  a_valid = '0;
  logic [1:0]  a_ready;
  logic [31:0] a_odata;
  logic [0:0]  a_src;
  logic        a_ov;
  logic        a_or = 1'b0;

  // N=4, WIDTH=32, round-robin (b) and fixed priority (c) on shared inputs
  logic [127:0] b_data = '0;
  logic [3:0]   b_valid = '0;
  logic         b_or = 1'b0;
  logic [3:0]   b_ready, c_ready;
  logic [31:0]  b_odata, c_odata;
  logic [1:0]   b_src, c_src;
  logic         b_ov, c_ov;

  // N=1, WIDTH=5
  logic [4:0] d_data = '0;
  logic [0:0] d_valid = '0;
  logic [0:0] d_ready;
  logic [4:0] d_odata;
  logic [0:0] d_src;
  logic       d_ov;
  logic       d_or = 1'b0;

  mux_arb_reg #(.WIDTH(32), .N(2), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_src(a_src), .out_valid(a_ov), .out_ready(a_or));

  mux_arb_reg #(.WIDTH(32), .N(4), .MODE(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_src(b_src), .out_valid(b_ov), .out_ready(b_or));

  mux_arb_reg #(.WIDTH(32), .N(4), .MODE(1)) dut_c (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_src(c_src), .out_valid(c_ov), .out_ready(b_or));

  mux_arb_reg #(.WIDTH(5), .N(1), .MODE(0)) dut_d (
    .clk(clk), .reset(reset), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
    .out_data(d_odata), .out_src(d_src), .out_valid(d_ov), .out_ready(d_or));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with every channel requesting
    reset   = 1'b1;
    a_valid = 2'b11;
    a_data  = {32'hDEADBEEF, 32'h0000_0001};
    a_or    = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(a_ov), 64'(0));
    check("rst_out_data", 64'(a_odata), 64'(0));
    check("rst_out_src", 64'(a_src), 64'(0));
    check("rst_in_ready", 64'(a_ready), 64'(0));
    check("rst_b_out_valid", 64'(b_ov), 64'(0));

    reset = 1'b0;
    #1;
    check("first_in_ready", 64'(a_ready), 64'(2'b01));
    tick();
    check("first_src", 64'(a_src), 64'(0));
    check("first_data", 64'(a_odata), 64'(32'h1));
    check("first_valid", 64'(a_ov), 64'(1));
    a_valid = 2'b00;
    tick();
    check("idle_valid", 64'(a_ov), 64'(0));

    // Single transfer from channel 1, pointer wraps to 0
    a_valid = 2'b10;
    tick();
    check("single_valid", 64'(a_ov), 64'(1));
    check("single_data", 64'(a_odata), 64'(32'hDEADBEEF));
    check("single_src", 64'(a_src), 64'(1));
    a_valid = 2'b11;
    tick();
    check("wrap_src", 64'(a_src), 64'(0));
    check("wrap_data", 64'(a_odata), 64'(32'h1));

    // Drain: valid falls after acceptance, data holds
    a_valid = 2'b00;
    tick();
    check("drain_valid", 64'(a_ov), 64'(0));
    check("drain_data_hold", 64'(a_odata), 64'(32'h1));
    check("drain_src_hold", 64'(a_src), 64'(0));

    // Backpressure: ch0 word stalls while ch1 waits
    a_valid = 2'b01;
    tick();
    check("bp_load_data", 64'(a_odata), 64'(32'h1));
    a_or    = 1'b0;
    a_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 64'(a_ready), 64'(0));
      tick();
      check("bp_data", 64'(a_odata), 64'(32'h1));
      check("bp_src", 64'(a_src), 64'(0));
      check("bp_valid", 64'(a_ov), 64'(1));
    end
    a_or = 1'b1;
    #1;
    check("bp_release_ready", 64'(a_ready), 64'(2'b10));
    tick();
    check("bp_release_data", 64'(a_odata), 64'(32'hDEADBEEF));
    check("bp_release_src", 64'(a_src), 64'(1));
    check("bp_release_valid", 64'(a_ov), 64'(1));

    // Mid-stall reset discards the held word
    a_or    = 1'b0;
    a_valid = 2'b01;
    tick();
    check("stall_hold_data", 64'(a_odata), 64'(32'hDEADBEEF));
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(a_ov), 64'(0));
    reset   = 1'b0;
    a_valid = 2'b00;
    a_or    = 1'b1;
    tick();
    check("midrst_no_deliver", 64'(a_ov), 64'(0));
    a_valid = 2'b11;
    tick();
    check("midrst_ptr_zero", 64'(a_src), 64'(0));
    a_valid = 2'b00;
    tick();

    // Round-robin vs fixed priority, N=4, all valid
    b_data  = {32'd19, 32'd18, 32'd17, 32'd16};
    b_valid = 4'b1111;
    b_or    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_src", 64'(b_src), 64'(k % 4));
      check("rr_data", 64'(b_odata), 64'(16 + k % 4));
      check("fp_src", 64'(c_src), 64'(0));
      check("fp_data", 64'(c_odata), 64'(16));
    end
    // Sparse requests: pointer sits at 0, channels 1 and 3 valid
    b_valid = 4'b1010;
    tick();
    check("rr_sparse_src1", 64'(b_src), 64'(1));
    check("fp_sparse_src", 64'(c_src), 64'(1));
    tick();
    check("rr_sparse_src3", 64'(b_src), 64'(3));
    b_valid = 4'b0000;
    tick();
    check("rr_idle_valid", 64'(b_ov), 64'(0));

    // Single-channel pipeline stage
    d_data  = 5'h1F;
    d_valid = 1'b1;
    d_or    = 1'b1;
    #1;
    check("n1_in_ready", 64'(d_ready), 64'(1));
    tick();
    check("n1_valid", 64'(d_ov), 64'(1));
    check("n1_data", 64'(d_odata), 64'(5'h1F));
    check("n1_src", 64'(d_src), 64'(0));
    d_valid = 1'b0;
    tick();
    check("n1_drain", 64'(d_ov), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
